serial_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) mating with the team's existing serial transmitter: idle-high line, one low start bit, 8 data bits, one high stop bit. Synchronises the line into the `clk12` domain, detects and verifies the start bit, samples each bit at mid-bit, checks the stop bit and hands the byte to the consumer over a valid/ready handshake. Sits at the device's RX pin, feeding the command/byte parser.

---
 rtl/serial_pkg.sv | 8 +
 rtl/serial_sync.sv | 17 +
 rtl/serial_rx.sv | 104 ++++++++++
 tb/tb_serial_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and timing helpers for the serial receiver path
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    localparam int DATA_BITS = 8;
    function automatic int half_of(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction
endpackage

// File: rtl/serial_sync.sv
// serial_sync: flop-chain synchroniser for an asynchronous input, idle-high reset value
module serial_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end
    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 LSB-first receiver with mid-bit sampling, break handling and a valid/ready holding register
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk12,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_C = CW'(half_of(CLKS_PER_BIT));
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;
    rx_state_t state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [2:0] bit_d, bit_q;
    logic [DATA_BITS-1:0] shift_d, shift_q, data_d, data_q;
    logic valid_d, valid_q, ferr_d, ferr_q, ovr_d, ovr_q;

    serial_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk12),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = (HALF_C == '0) ? DATA : START;
                cnt_d   = (HALF_C == '0) ? '0 : CW'(1);
            end
            START: if (cnt_q == HALF_C) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            DATA: if (cnt_q == LAST_C) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == LAST_BIT) ? STOP : DATA;
            end else cnt_d = cnt_q + 1'b1;
            STOP: if (cnt_q == LAST_C) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : BREAK;
                ferr_d  = ~rx_s;
                // a byte may land in the same cycle the old one is taken
                if (rx_s && (!valid_q || rx_ready)) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
                ovr_d = rx_s & valid_q & ~rx_ready;
            end else cnt_d = cnt_q + 1'b1;
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk12) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = state_q != IDLE;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx at one and four clocks per bit
module tb_serial_rx;
    localparam int EV_BYTE = 256;
    localparam int EV_FE   = 512;
    localparam int EV_OVR  = 768;

    logic clk = 1'b0, rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] da, db;
    logic va, vb, ba, bb, fa, fb, oa, ob;
    int checks = 0, errors = 0;
    int exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    serial_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_a (
        .clk12(clk), .rst(rst), .rx(rx_a), .rx_ready(rdy_a), .rx_data(da),
        .rx_valid(va), .rx_busy(ba), .frame_err(fa), .overrun(oa)
    );
    serial_rx #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) u_b (
        .clk12(clk), .rst(rst), .rx(rx_b), .rx_ready(rdy_b), .rx_data(db),
        .rx_valid(vb), .rx_busy(bb), .frame_err(fb), .overrun(ob)
    );

    task automatic cmp(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic chk_a(input int got);
        if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL A_unexpected got %0h want none", got);
        end else cmp("A_event", got, exp_a.pop_front());
    endtask

    task automatic chk_b(input int got);
        if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL B_unexpected got %0h want none", got);
        end else cmp("B_event", got, exp_b.pop_front());
    endtask

    always @(negedge clk) if (!rst) begin
        if (va && rdy_a) chk_a(EV_BYTE + int'(da));
        if (fa) chk_a(EV_FE);
        if (oa) chk_a(EV_OVR);
    end

    always @(negedge clk) if (!rst) begin
        if (vb && rdy_b) chk_b(EV_BYTE + int'(db));
        if (fb) chk_b(EV_FE);
        if (ob) chk_b(EV_OVR);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_a = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            tick();
        end
        rx_a = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_b(input logic [7:0] b, input logic stop);
        rx_b = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            rx_b = b[i];
            repeat (4) tick();
        end
        rx_b = stop;
        repeat (4) tick();
    endtask

    initial begin
        int n;
        logic [7:0] lb [4];
        lb = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        repeat (3) tick();
        cmp("rst_valid_a", va, 0);
        cmp("rst_valid_b", vb, 0);
        cmp("rst_data_a", da, 0);
        cmp("rst_data_b", db, 0);
        cmp("rst_busy_a", ba, 0);
        cmp("rst_busy_b", bb, 0);
        cmp("rst_ferr_b", fb, 0);
        cmp("rst_ovr_b", ob, 0);
        rst = 1'b0;
        repeat (3) tick();

        foreach (lb[i]) exp_a.push_back(EV_BYTE + int'(lb[i]));
        foreach (lb[i]) send_a(lb[i]);
        repeat (5) tick();

        rx_b = 1'b0;
        tick();
        rx_b = 1'b1;
        n = 0;
        repeat (12) begin
            tick();
            if (bb) n++;
        end
        cmp("glitch_busy_1to3", int'(n >= 1 && n <= 3), 1);

        exp_b.push_back(EV_FE);
        send_b(8'h3C, 1'b0);
        repeat (20) tick();
        rx_b = 1'b1;
        repeat (8) tick();
        exp_b.push_back(EV_BYTE + 8'h81);
        send_b(8'h81, 1'b1);
        repeat (8) tick();

        rdy_b = 1'b0;
        exp_b.push_back(EV_OVR);
        exp_b.push_back(EV_BYTE + 8'h12);
        send_b(8'h12, 1'b1);
        tick();
        send_b(8'h34, 1'b1);
        repeat (6) tick();
        cmp("ovr_hold_valid", vb, 1);
        cmp("ovr_hold_data", db, 8'h12);
        rdy_b = 1'b1;
        tick();
        cmp("ovr_valid_drop", vb, 0);

        rx_b = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            rx_b = 8'hC7 >> i;
            repeat (4) tick();
        end
        rx_b = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        rx_b = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        cmp("abort_busy", bb, 0);
        cmp("abort_valid", vb, 0);
        cmp("abort_data", db, 0);
        exp_b.push_back(EV_BYTE + 8'h5A);
        send_b(8'h5A, 1'b1);
        repeat (6) tick();

        rdy_b = 1'b0;
        exp_b.push_back(EV_BYTE + 8'h11);
        exp_b.push_back(EV_BYTE + 8'h22);
        send_b(8'h11, 1'b1);
        repeat (4) tick();
        cmp("pre_swap_valid", vb, 1);
        fork
            send_b(8'h22, 1'b1);
            begin
                repeat (39) tick();
                rdy_b = 1'b1;
                tick();
                rdy_b = 1'b0;
            end
        join
        cmp("swap_valid", vb, 1);
        cmp("swap_data", db, 8'h22);
        rdy_b = 1'b1;
        repeat (5) tick();

        cmp("A_drain", exp_a.size(), 0);
        cmp("B_drain", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
